// File: rtl/voltmeter_pkg.sv
// Shared types and helpers for the voltmeter conversion path.
// Holds the gate sequencer state enum, the fault code values and a ceil-log2 helper.
// Used at elaboration only. There is no runtime logic and no backpressure.
package voltmeter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REF,
    ST_SETTLE,
    ST_START,
    ST_CONVERT,
    ST_HOLD,
    ST_FAULT
  } gate_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_REF_LOST = 2'd1;
  localparam logic [1:0] FAULT_ABORT    = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

  // Returns the number of bits needed to index v distinct values, i.e. ceil(log2(v)).
  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_down_counter.sv
// Loadable down-counter. The settle and convert phases of the gate sequencer share it.
// Latency: value updates one cycle after load/dec. is_one decodes the registered value.
// Backpressure: none. load takes priority over dec, and the count holds at zero.
// Ports: clk_i, rst_ni, load, load_val, dec -> value, is_one
module gate_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_one
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign is_one = (value == W'(1));

endmodule

// File: rtl/conv_gate_seq.sv
// Conversion gate sequencer. It runs one ADC conversion per request once the reference is OK and settled.
// Latency: start fires SETTLE_TICKS+2 cycles after the request. The result registers one cycle after adc_done_i.
// Backpressure: the result is held until result_ready_i. Requests arriving while busy or faulted are dropped.
// Ports: reference status inputs (ref_ok_i, ref_fall_i, guard_active_i, low_long_i), meas_req_i, ADC handshake,
//        result valid/ready, fault_clr_i -> busy_o, adc_start_o, result_*, fault_o, fault_code_o.
// Optional macro CONV_GATE_STATS_EN adds abort_cnt_o / timeout_cnt_o. These are saturating and cleared only by reset.
module conv_gate_seq
  import voltmeter_pkg::*;
#(
  parameter int SETTLE_TICKS = 64,
  parameter int CONV_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int DATA_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ref_ok_i,
  input  logic              ref_fall_i,
  input  logic              guard_active_i,
  input  logic              low_long_i,
  input  logic              meas_req_i,
  input  logic              adc_done_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              result_ready_i,
  input  logic              fault_clr_i,
  output logic              busy_o,
  output logic              adc_start_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_data_o,
  output logic              fault_o,
  output logic [1:0]        fault_code_o
`ifdef CONV_GATE_STATS_EN
  ,
  output logic [7:0]        abort_cnt_o,
  output logic [7:0]        timeout_cnt_o
`endif
);

  localparam int CNT_MAX = (SETTLE_TICKS > CONV_TIMEOUT) ? SETTLE_TICKS : CONV_TIMEOUT;
  localparam int CW      = CLOG2(CNT_MAX + 1);
  localparam int RW      = CLOG2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  gate_state_t    state_q, state_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [1:0]     code_d;
  logic           cnt_load, cnt_dec, cnt_is_one;
  logic [CW-1:0]  cnt_load_val, cnt_value;
  logic           capture;
  logic           abort_evt, tmo_evt;

  gate_down_counter #(.W(CW)) u_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    code_d       = fault_code_o;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    capture      = 1'b0;
    abort_evt    = 1'b0;
    tmo_evt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (meas_req_i) state_d = ST_WAIT_REF;
      end
      ST_WAIT_REF: begin
        if (low_long_i) begin
          state_d = ST_FAULT;
          code_d  = FAULT_REF_LOST;
        end else if (ref_ok_i && !guard_active_i) begin
          state_d      = ST_SETTLE;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(SETTLE_TICKS);
        end
      end
      ST_SETTLE: begin
        cnt_dec = 1'b1;
        if (low_long_i) begin
          state_d = ST_FAULT;
          code_d  = FAULT_REF_LOST;
        end else if (!ref_ok_i || ref_fall_i || guard_active_i) begin
          // Losing the reference while settling costs no retry. The settle just starts over.
          state_d = ST_WAIT_REF;
        end else if (cnt_is_one) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_load     = 1'b1;
        cnt_load_val = CW'(CONV_TIMEOUT);
        if (low_long_i) begin
          state_d = ST_FAULT;
          code_d  = FAULT_REF_LOST;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        cnt_dec = 1'b1;
        if (low_long_i) begin
          state_d = ST_FAULT;
          code_d  = FAULT_REF_LOST;
        end else if (ref_fall_i || !ref_ok_i) begin
          // A drop outranks adc_done_i. A result taken under a bad reference is never trusted.
          abort_evt = 1'b1;
          retry_d   = retry_q + 1'b1;
          if (retry_d == RETRY_LIMIT) begin
            state_d = ST_FAULT;
            code_d  = FAULT_ABORT;
          end else begin
            state_d = ST_WAIT_REF;
          end
        end else if (adc_done_i) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_is_one) begin
          tmo_evt = 1'b1;
          state_d = ST_FAULT;
          code_d  = FAULT_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (result_valid_o && result_ready_i) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr_i) begin
          state_d = ST_IDLE;
          code_d  = FAULT_NONE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so each one is valid in the cycle its state is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      retry_q        <= '0;
      busy_o         <= 1'b0;
      adc_start_o    <= 1'b0;
      result_valid_o <= 1'b0;
      result_data_o  <= '0;
      fault_o        <= 1'b0;
      fault_code_o   <= FAULT_NONE;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      busy_o         <= (state_d == ST_WAIT_REF) || (state_d == ST_SETTLE) ||
                        (state_d == ST_START) || (state_d == ST_CONVERT) ||
                        (state_d == ST_HOLD);
      adc_start_o    <= (state_d == ST_START);
      result_valid_o <= (state_d == ST_HOLD);
      fault_o        <= (state_d == ST_FAULT);
      fault_code_o   <= code_d;
      if (capture) result_data_o <= adc_data_i;
    end
  end

`ifdef CONV_GATE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abort_cnt_o   <= '0;
      timeout_cnt_o <= '0;
    end else begin
      if (abort_evt && (abort_cnt_o != 8'hFF)) abort_cnt_o <= abort_cnt_o + 8'd1;
      if (tmo_evt && (timeout_cnt_o != 8'hFF)) timeout_cnt_o <= timeout_cnt_o + 8'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = abort_evt ^ tmo_evt;
`endif

endmodule

// File: tb/tb_conv_gate_seq.sv
// Directed bench for conv_gate_seq with small settle, timeout and retry limits.
// Inputs change 1 time unit after the rising edge. Outputs are sampled in that same window, so each sample is the registered state of the current cycle.
// Every bounded wait reports a comparison when it gives up.
module tb_conv_gate_seq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ref_ok = 1'b1, ref_fall = 1'b0, guard_active = 1'b0, low_long = 1'b0;
  logic          meas_req = 1'b0, adc_done = 1'b0, result_ready = 1'b0, fault_clr = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          busy, adc_start, result_valid, fault;
  logic [DW-1:0] result_data;
  logic [1:0]    fault_code;
`ifdef CONV_GATE_STATS_EN
  logic [7:0]    abort_cnt, timeout_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_gate_seq #(.SETTLE_TICKS(4), .CONV_TIMEOUT(8), .MAX_RETRY(3), .DATA_W(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ref_ok_i       (ref_ok),
    .ref_fall_i     (ref_fall),
    .guard_active_i (guard_active),
    .low_long_i     (low_long),
    .meas_req_i     (meas_req),
    .adc_done_i     (adc_done),
    .adc_data_i     (adc_data),
    .result_ready_i (result_ready),
    .fault_clr_i    (fault_clr),
    .busy_o         (busy),
    .adc_start_o    (adc_start),
    .result_valid_o (result_valid),
    .result_data_o  (result_data),
    .fault_o        (fault),
    .fault_code_o   (fault_code)
`ifdef CONV_GATE_STATS_EN
    ,
    .abort_cnt_o    (abort_cnt),
    .timeout_cnt_o  (timeout_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until adc_start is seen, with a bounded budget.
  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (adc_start !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk(tag, {31'd0, adc_start}, 32'd1);
  endtask

  task automatic request();
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
  endtask

  int starts;

  initial begin
    // Reset state.
    step();
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_start", {31'd0, adc_start}, 0);
    chk("rst_valid", {31'd0, result_valid}, 0);
    chk("rst_data",  {16'd0, result_data}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_code",  {30'd0, fault_code}, 0);
    rst_ni = 1'b1;
    step();

    // Nominal: request at n, start at n+6, done at n+10, valid at n+11, ready at n+13, idle at n+14.
    request();
    chk("nom_busy_wait", {31'd0, busy}, 1);
    repeat (4) step();
    chk("nom_no_early_start", {31'd0, adc_start}, 0);
    step();
    chk("nom_start", {31'd0, adc_start}, 1);
    step();
    chk("nom_start_pulse", {31'd0, adc_start}, 0);
    repeat (3) step();
    adc_done = 1'b1; adc_data = 16'h1234;
    step();
    adc_done = 1'b0; adc_data = '0;
    chk("nom_valid", {31'd0, result_valid}, 1);
    chk("nom_data",  {16'd0, result_data}, 32'h1234);
    step(); step();
    chk("nom_hold", {31'd0, result_valid}, 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("nom_idle_valid", {31'd0, result_valid}, 0);
    chk("nom_idle_busy",  {31'd0, busy}, 0);

    // adc_done in IDLE is ignored.
    adc_done = 1'b1; adc_data = 16'h5555;
    step();
    adc_done = 1'b0;
    chk("idle_done_valid", {31'd0, result_valid}, 0);
    chk("idle_done_data",  {16'd0, result_data}, 32'h1234);

    // Settle interrupt: drop during SETTLE cycle 2 for 3 cycles, then a full re-settle and exactly one start.
    request();                      // n+1 WAIT_REF
    step();                         // n+2 SETTLE cycle 1
    step();                         // n+3 SETTLE cycle 2
    ref_ok = 1'b0; ref_fall = 1'b1;
    step(); ref_fall = 1'b0;        // n+4
    step(); step();                 // n+6
    ref_ok = 1'b1;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (adc_start) starts++;
      step();                       // n+7 .. n+11
    end
    chk("settle_restart_start", {31'd0, adc_start}, 1);
    starts += 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (adc_start) starts++;
      if (i == 0) begin
        adc_done = 1'b1; adc_data = 16'hBEEF;
      end else begin
        adc_done = 1'b0;
      end
    end
    chk("settle_one_start", starts, 1);
    chk("settle_data", {16'd0, result_data}, 32'hBEEF);
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // Abort/retry: three drops in CONVERT, then FAULT(ABORT).
    request();
    for (int r = 0; r < 3; r++) begin
      wait_start("abort_start");
      step();
      ref_fall = 1'b1;
      step();
      ref_fall = 1'b0;
      if (r < 2) chk("abort_retry_busy", {31'd0, busy}, 1);
    end
    chk("abort_fault", {31'd0, fault}, 1);
    chk("abort_code",  {30'd0, fault_code}, 2);
    chk("abort_busy",  {31'd0, busy}, 0);
    clear_fault();
    chk("abort_clr_fault", {31'd0, fault}, 0);
    chk("abort_clr_code",  {30'd0, fault_code}, 0);

    // Timeout: no done for 8 CONVERT cycles.
    request();
    wait_start("tmo_start");
    repeat (8) step();
    chk("tmo_not_yet", {31'd0, fault}, 0);
    step();
    chk("tmo_fault", {31'd0, fault}, 1);
    chk("tmo_code",  {30'd0, fault_code}, 3);
    clear_fault();

    // Done on the eighth CONVERT cycle wins over the timeout.
    request();
    wait_start("tmo2_start");
    repeat (8) step();
    adc_done = 1'b1; adc_data = 16'hA5C3;
    step();
    adc_done = 1'b0;
    chk("tmo2_valid", {31'd0, result_valid}, 1);
    chk("tmo2_data",  {16'd0, result_data}, 32'hA5C3);
    chk("tmo2_fault", {31'd0, fault}, 0);
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // Drop together with done discards the result, and the retry then succeeds.
    request();
    wait_start("drop_done_start");
    step();
    ref_fall = 1'b1; adc_done = 1'b1; adc_data = 16'h7777;
    step();
    ref_fall = 1'b0; adc_done = 1'b0;
    chk("drop_done_valid", {31'd0, result_valid}, 0);
    chk("drop_done_data",  {16'd0, result_data}, 32'hA5C3);
    chk("drop_done_busy",  {31'd0, busy}, 1);
    wait_start("drop_retry_start");
    step();
    adc_done = 1'b1; adc_data = 16'h4321;
    step();
    adc_done = 1'b0;
    chk("drop_retry_data", {16'd0, result_data}, 32'h4321);
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // Guard holds WAIT_REF.
    guard_active = 1'b1;
    request();
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (adc_start) starts++;
    end
    chk("guard_no_start", starts, 0);
    guard_active = 1'b0;
    wait_start("guard_release_start");
    step();
    adc_done = 1'b1; adc_data = 16'h0F0F;
    step();
    adc_done = 1'b0;
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // low_long in WAIT_REF gives FAULT(REF_LOST). Later requests are ignored until cleared.
    request();
    low_long = 1'b1;
    step();
    low_long = 1'b0;
    chk("ll_fault", {31'd0, fault}, 1);
    chk("ll_code",  {30'd0, fault_code}, 1);
    request();
    step();
    chk("ll_req_ignored_busy",  {31'd0, busy}, 0);
    chk("ll_req_ignored_fault", {31'd0, fault}, 1);
    clear_fault();
    chk("ll_clr", {31'd0, fault}, 0);

`ifdef CONV_GATE_STATS_EN
    chk("stats_abort",   {24'd0, abort_cnt}, 4);
    chk("stats_timeout", {24'd0, timeout_cnt}, 1);
`endif

    // Reset mid-CONVERT.
    request();
    wait_start("rst_mid_start");
    step();
    rst_ni = 1'b0;
    #1;
    chk("rstm_busy",  {31'd0, busy}, 0);
    chk("rstm_start", {31'd0, adc_start}, 0);
    chk("rstm_valid", {31'd0, result_valid}, 0);
    chk("rstm_data",  {16'd0, result_data}, 0);
    chk("rstm_fault", {31'd0, fault}, 0);
    step();
    rst_ni = 1'b1;
    step();
    adc_done = 1'b1; adc_data = 16'h9999;
    step();
    adc_done = 1'b0;
    chk("rstm_done_ignored", {31'd0, result_valid}, 0);
    chk("rstm_done_data",    {16'd0, result_data}, 0);

`ifdef CONV_GATE_STATS_EN
    chk("stats_rst_abort", {24'd0, abort_cnt}, 0);
    for (int g = 0; g < 86; g++) begin
      request();
      for (int r = 0; r < 3; r++) begin
        wait_start("sat_start");
        step();
        ref_fall = 1'b1;
        step();
        ref_fall = 1'b0;
      end
      clear_fault();
    end
    chk("stats_abort_sat", {24'd0, abort_cnt}, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_gate_seq.md
# conv_gate_seq

Conversion gate sequencer downstream of the reference qualification filter. Consumes the qualified reference status, guard flag, edge pulses and low-too-long flag, and sequences one ADC conversion per measurement request. A conversion is started only after the reference has been OK and settled. Conversions interrupted by a reference drop are discarded and retried. Persistent faults are latched until software clears them.

## Interface
- SETTLE_TICKS, 64, cycles reference must stay OK before start (>=1)
- CONV_TIMEOUT, 4096, max cycles in CONVERT awaiting adc_done_i (>=1)
- MAX_RETRY, 3, aborted conversions tolerated per request before fault (>=1)
- DATA_W, 16, ADC result width
- clk_i  in  1  single clock
- rst_ni  in  1  **reset: asynchronous, active-low**
- ref_ok_i  in  1  qualified reference OK (already masked by guard)
- ref_fall_i  in  1  1-cycle pulse, reference OK 1->0
- guard_active_i  in  1  reconfig hold-off window active
- low_long_i  in  1  reference bad too long
- meas_req_i  in  1  1-cycle measurement request
- adc_done_i  in  1  ADC conversion complete strobe
- adc_data_i  in  DATA_W  ADC result, valid with adc_done_i
- result_ready_i  in  1  consumer accepts result
- fault_clr_i  in  1  clears latched fault
- busy_o  out  1  request in progress
- adc_start_o  out  1  1-cycle conversion start
- result_valid_o  out  1  result held for handshake
- result_data_o  out  DATA_W  captured result
- fault_o  out  1  latched fault
- fault_code_o  out  2  0 none, 1 REF_LOST, 2 ABORT, 3 TIMEOUT

## Operation
- Reset: state IDLE. All outputs are 0. Retry count is 0. Counter is 0.
- States: IDLE, WAIT_REF, SETTLE, START, CONVERT, HOLD, FAULT.
- busy_o=1 in WAIT_REF, SETTLE, START, CONVERT and HOLD.
- IDLE: meas_req_i -> WAIT_REF. meas_req_i is ignored in every other state.
- WAIT_REF: ref_ok_i && !guard_active_i -> SETTLE, loading the counter with SETTLE_TICKS.
- SETTLE: counter decrements each cycle.
  - !ref_ok_i, ref_fall_i or guard_active_i -> WAIT_REF. No retry is consumed.
  - Counter==1 with the reference still OK -> START.
- START: adc_start_o=1 for exactly this cycle. Counter is loaded with CONV_TIMEOUT. Next state is CONVERT.
- CONVERT priority, highest first:
  - low_long_i -> FAULT(REF_LOST).
  - ref_fall_i or !ref_ok_i -> discard the conversion and increment the retry count. If the new count equals MAX_RETRY -> FAULT(ABORT); otherwise -> WAIT_REF.
  - adc_done_i -> capture adc_data_i into result_data_o, then HOLD.
  - Counter==1 -> FAULT(TIMEOUT).
- In WAIT_REF, SETTLE and START, low_long_i -> FAULT(REF_LOST) with top priority.
- HOLD: result_valid_o=1 and result_data_o is stable.
  - Reference events are ignored, because the result is already qualified.
  - valid && result_ready_i -> IDLE, and the retry count clears.
- FAULT: fault_o=1 and fault_code_o is held.
  - fault_clr_i -> IDLE, clearing fault_o, the code and the retry count.
  - fault_clr_i in other states has no effect.
- adc_done_i outside CONVERT is ignored.
- Retry counter width is CLOG2(MAX_RETRY+1).
- The shared counter width is CLOG2(max(SETTLE_TICKS, CONV_TIMEOUT)+1).

## Timing
- meas_req_i at cycle n with reference OK: WAIT_REF at n+1, SETTLE at n+2, adc_start_o high at n+2+SETTLE_TICKS.
- adc_done_i at cycle m: result_valid_o and result_data_o update at m+1.
- Handshake at cycle k: result_valid_o=0 and state IDLE at k+1. A new meas_req_i is accepted from k+1.
- Timeout fires when adc_done_i has been absent for CONV_TIMEOUT cycles of CONVERT.
  - adc_done_i in the final CONVERT cycle wins over timeout.
- Reference drop in the same cycle as adc_done_i: the result is discarded.
- rst_ni low mid-operation returns to IDLE immediately. No adc_start_o or result is emitted.
- All outputs are registered.

## Configuration
- Macro CONV_GATE_STATS_EN.
- Defined: adds outputs abort_cnt_o[7:0] and timeout_cnt_o[7:0].
  - These are saturating counters of discarded conversions and TIMEOUT faults.
  - They clear only on reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package voltmeter_pkg holds:
  - the state enum;
  - fault code constants FAULT_NONE, FAULT_REF_LOST, FAULT_ABORT, FAULT_TIMEOUT;
  - the CLOG2 function.
- One sub-module, gate_down_counter: a loadable down-counter with load, value and is_one outputs, shared by SETTLE and CONVERT.

## Test plan
- Nominal: ref_ok_i=1, SETTLE_TICKS=4, meas_req_i at cycle 10 -> adc_start_o at 16. adc_done_i with 0x1234 at 20 -> result_valid_o at 21 with 0x1234. Ready at 23 -> IDLE at 24.
- Settle interrupt: ref_ok_i drops in SETTLE cycle 2 and returns 3 cycles later -> full re-settle. Exactly one adc_start_o is issued. Retry count stays 0.
- Abort/retry: MAX_RETRY=3, ref_fall_i in CONVERT three times -> three adc_start_o. After the third abort, fault_o=1 and fault_code_o=2. fault_clr_i -> IDLE.
- Timeout: CONV_TIMEOUT=8, no adc_done_i -> fault_code_o=3 after 8 CONVERT cycles. adc_done_i on cycle 8 instead -> result captured, no fault.
- low_long_i asserted in WAIT_REF -> next cycle FAULT with code 1. Later meas_req_i is ignored until fault_clr_i.
- Reset mid-CONVERT: rst_ni low -> all outputs 0. A later adc_done_i in IDLE produces no result. With CONV_GATE_STATS_EN defined, abort_cnt_o saturates at 255.
